// File: rtl/fetch_unit.sv
// Instruction-fetch stage.
// Owns the PC and issues one outstanding request at a time to instruction memory.
// Drives the F/D register inputs (instr_f, pc_f) and its load enable (fd_write).
// A word returned while decode is stalled is parked in a hold register.
// A redirect that lands while a request is in flight is remembered. The stale
// response is then thrown away when it finally arrives.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic        fd_write
);

  // REQ : request outstanding for r_pc; a same-cycle ack may deliver directly
  // HOLD: a fetched word waits in the hold registers for decode to un-stall
  // DROP: the in-flight request is wrong-path; r_target holds the real next PC
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;
  logic [31:0] r_target;

  logic [1:0]  w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_hold_instr_next;
  logic [31:0] w_hold_pc_next;
  logic [31:0] w_target_next;
  logic [31:0] w_pc_inc;

  // Sequential PC. This addition wraps naturally modulo 2^32.
  assign w_pc_inc = r_pc + PC_STEP;

  // Next-state logic. Redirect outranks ack, and ack outranks stall.
  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_hold_instr_next = r_hold_instr;
    w_hold_pc_next    = r_hold_pc;
    w_target_next     = r_target;
    case (r_state)
      S_REQ: begin
        if (redirect) begin
          if (imem_ack) begin
            // The response completes now. Drop it and refetch from the target.
            w_pc_next = redirect_pc;
          end else begin
            // The address must stay stable until the ack arrives.
            // Park the target meanwhile.
            w_target_next = redirect_pc;
            w_state_next  = S_DROP;
          end
        end else if (imem_ack) begin
          w_pc_next = w_pc_inc;
          if (stall_d) begin
            w_hold_instr_next = imem_rdata;
            w_hold_pc_next    = r_pc;
            w_state_next      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          // The held word is wrong-path. Simply abandon it.
          w_pc_next    = redirect_pc;
          w_state_next = S_REQ;
        end else if (!stall_d) begin
          w_state_next = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect) begin
          w_target_next = redirect_pc;
        end
        if (imem_ack) begin
          // A redirect in the same cycle is newer than the parked target.
          w_pc_next    = redirect ? redirect_pc : r_target;
          w_state_next = S_REQ;
        end
      end
      default: begin
        w_state_next = S_REQ;
      end
    endcase
  end

  // Output decode. Everything is zero under reset. Otherwise emit a bubble
  // unless a valid, non-flushed word can be loaded this cycle.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = 32'h0;
    instr_f   = 32'h0;
    pc_f      = 32'h0;
    fd_write  = 1'b0;
    if (!rst) begin
      fd_write = !stall_d;
      instr_f  = NOP;
      case (r_state)
        S_REQ: begin
          imem_req  = 1'b1;
          imem_addr = r_pc;
          if (imem_ack && !redirect && !stall_d) begin
            instr_f = imem_rdata;
            pc_f    = r_pc;
          end
        end
        S_HOLD: begin
          if (!redirect && !stall_d) begin
            instr_f = r_hold_instr;
            pc_f    = r_hold_pc;
          end
        end
        S_DROP: begin
          imem_req  = 1'b1;
          imem_addr = r_pc;
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

  // State registers. Reset abandons any outstanding access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_hold_instr <= 32'h0;
      r_hold_pc    <= 32'h0;
      r_target     <= 32'h0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_hold_instr <= w_hold_instr_next;
      r_hold_pc    <= w_hold_pc_next;
      r_target     <= w_target_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit.
// The stimulus pushes each instruction expected at F/D, in order.
// A negedge monitor pops an entry whenever the DUT loads a real instruction.
// The monitor also checks two things on every cycle:
//  - fd_write follows stall_d;
//  - bubbles carry pc 0 and the request address stays stable.
// Memory is a wait-state model whose data word is the address XOR a constant.
module tb_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0200;
  localparam logic [31:0] TB_NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_d;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic        fd_write;

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 0;
  int wcnt     = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } txn_t;
  txn_t exp_q[$];

  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  fetch_unit #(
    .RESET_PC(TB_RESET_PC),
    .PC_STEP (32'd4),
    .NOP     (TB_NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_d    (stall_d),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_f    (instr_f),
    .pc_f       (pc_f),
    .fd_write   (fd_write)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory model: ack after 'lat' wait cycles, same cycle when lat=0.
  assign imem_ack   = imem_req && (wcnt >= lat);
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wcnt <= 0;
    else                              wcnt <= wcnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_exp(input logic [31:0] pc);
    txn_t t;
    t.pc    = pc;
    t.instr = mem_word(pc);
    exp_q.push_back(t);
  endtask

  // One cycle: drive the inputs just after the edge, then let the logic settle.
  task automatic step(input logic r, input logic s, input logic rd,
                      input logic [31:0] rpc, input int l);
    @(posedge clk);
    #1;
    rst         = r;
    stall_d     = s;
    redirect    = rd;
    redirect_pc = rpc;
    lat         = l;
    #3;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   32'(imem_req),  32'h0);
    check({tag, "_addr"},  imem_addr,      32'h0);
    check({tag, "_instr"}, instr_f,        32'h0);
    check({tag, "_pc"},    pc_f,           32'h0);
    check({tag, "_fdw"},   32'(fd_write),  32'h0);
  endtask

  // Monitor and scoreboard.
  always @(negedge clk) begin
    txn_t t;
    if (rst) begin
      prev_pend <= 1'b0;
    end else begin
      check("fd_write_vs_stall", 32'(fd_write), 32'(!stall_d));
      if (prev_pend) begin
        check("req_held", 32'(imem_req), 32'h1);
        check("addr_stable", imem_addr, prev_addr);
      end
      prev_pend <= imem_req && !imem_ack;
      prev_addr <= imem_addr;
      if (fd_write && instr_f !== TB_NOP) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_delivery: got pc=%08h instr=%08h expected none", pc_f, instr_f);
        end else begin
          t = exp_q.pop_front();
          $display("deliver pc=%08h instr=%08h (expect pc=%08h)", pc_f, instr_f, t.pc);
          check("deliv_pc", pc_f, t.pc);
          check("deliv_instr", instr_f, t.instr);
        end
      end else if (fd_write) begin
        check("bubble_pc", pc_f, 32'h0);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall_d = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; lat = 0;

    // Reset: all outputs are forced to zero.
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 0);
    check_all_zero("rst");

    // Zero-wait memory: first fetch is at RESET_PC.
    // Then redirect to 0 for a back-to-back run.
    push_exp(32'h200); push_exp(32'h204);
    step(0, 0, 0, 32'h0, 0);
    check("first_addr", imem_addr, 32'h200);
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 1, 32'h0, 0);
    check("redir_ack_nop", instr_f, TB_NOP);
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 32'h0, 0);
      check("seq_pc", pc_f, 32'(i * 4));
    end

    // Two wait states: expected pattern is NOP, NOP, instr.
    push_exp(32'd16); push_exp(32'd20);
    step(0, 0, 0, 32'h0, 2);
    check("wait_addr", imem_addr, 32'd16);
    check("wait_nop", instr_f, TB_NOP);
    step(0, 0, 0, 32'h0, 2);
    check("wait_nop2", instr_f, TB_NOP);
    step(0, 0, 0, 32'h0, 2);
    check("wait_deliv", pc_f, 32'd16);
    step(0, 0, 0, 32'h0, 2);
    step(0, 0, 0, 32'h0, 2);
    step(0, 0, 0, 32'h0, 2);
    check("wait_deliv2", pc_f, 32'd20);

    // Stall for three cycles starting on the ack cycle for pc 24.
    push_exp(32'd24);
    step(0, 0, 0, 32'h0, 2);
    step(0, 0, 0, 32'h0, 2);
    step(0, 1, 0, 32'h0, 2);
    check("stall_fdw", 32'(fd_write), 32'h0);
    step(0, 1, 0, 32'h0, 2);
    check("hold_req", 32'(imem_req), 32'h0);
    step(0, 1, 0, 32'h0, 2);
    check("hold_req2", 32'(imem_req), 32'h0);
    step(0, 0, 0, 32'h0, 2);
    check("hold_release_pc", pc_f, 32'd24);

    // Redirect to 0x100 while the request for 28 is outstanding.
    push_exp(32'h100);
    step(0, 0, 1, 32'h100, 2);
    check("after_hold_addr", imem_addr, 32'd28);
    check("after_hold_req", 32'(imem_req), 32'h1);
    step(0, 0, 0, 32'h0, 2);
    step(0, 0, 0, 32'h0, 2);
    check("drop_discard", instr_f, TB_NOP);
    step(0, 0, 0, 32'h0, 2);
    check("drop_next_addr", imem_addr, 32'h100);
    step(0, 0, 0, 32'h0, 2);
    step(0, 0, 0, 32'h0, 2);
    check("drop_deliv", pc_f, 32'h100);

    // Sequence: redirect in HOLD, enter DROP, redirect again (latest wins).
    push_exp(32'h80);
    step(0, 0, 0, 32'h0, 2);
    step(0, 0, 0, 32'h0, 2);
    step(0, 1, 0, 32'h0, 2);
    step(0, 1, 1, 32'h40, 2);
    check("hold_redir_fdw", 32'(fd_write), 32'h0);
    step(0, 0, 1, 32'h60, 2);
    check("redir40_addr", imem_addr, 32'h40);
    step(0, 0, 1, 32'h80, 2);
    step(0, 0, 0, 32'h0, 2);
    check("drop2_addr", imem_addr, 32'h40);
    check("drop2_nop", instr_f, TB_NOP);
    step(0, 0, 0, 32'h0, 2);
    check("final_addr", imem_addr, 32'h80);
    step(0, 0, 0, 32'h0, 2);
    step(0, 0, 0, 32'h0, 2);
    check("final_deliv", pc_f, 32'h80);

    // Assert reset in the middle of DROP.
    step(0, 0, 1, 32'h300, 2);
    step(1, 0, 0, 32'h0, 2);
    check_all_zero("rst_drop");
    step(1, 0, 0, 32'h0, 2);
    push_exp(32'h200);
    step(0, 0, 0, 32'h0, 0);
    check("post_rst_addr", imem_addr, 32'h200);

    // PC wrap: 32'hFFFF_FFFC + 4 gives 0.
    push_exp(32'hFFFF_FFFC); push_exp(32'h0); push_exp(32'h4);
    step(0, 0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 32'h0, 0);
    check("wrap_hi_addr", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 32'h0, 0);
    check("wrap_addr", imem_addr, 32'h0);
    step(0, 0, 0, 32'h0, 0);

    // Park in HOLD so nothing further is delivered.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 32'h0, 0);
    @(negedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: owns the PC, issues single-outstanding requests to instruction memory, and drives the F/D pipeline register inputs (instr_f, pc_f) plus its load enable (fd_write).
- Absorbs variable memory latency, decode-stage stalls and branch redirects.
- Inserts NOP bubbles (32'h0) whenever no valid instruction is available or a fetched one is wrong-path.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 4, PC increment per sequential fetch
NOP, 32'h0000_0000, bubble instruction sent to F/D

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall_d  in  1  decode stalled; F/D must hold
redirect  in  1  branch/jump resolved taken; one-cycle pulse
redirect_pc  in  32  redirect target, valid with redirect
imem_req  out  1  memory request
imem_addr  out  32  request address, stable while imem_req=1 and no ack
imem_ack  in  1  response; imem_rdata valid this cycle
imem_rdata  in  32  instruction word
instr_f  out  32  instruction to F/D register
pc_f  out  32  address of instr_f (0 when instr_f is a bubble)
fd_write  out  1  F/D load enable

Behaviour:
- Reset (rst=1 at a clk edge): state<=REQ, pc_q<=RESET_PC, hold and target registers cleared. While rst=1, all outputs are forced to 0. The first request is issued in the first cycle with rst=0.
- Reset mid-request abandons the outstanding access. Instruction memory is reset by the same rst.
- Common rule: fd_write = !stall_d in every non-reset cycle.
- A cycle delivers only when fd_write=1 and a valid, non-flushed instruction exists. Otherwise instr_f=NOP and pc_f=0.
- REQ state: imem_req=1, imem_addr=pc_q.
  - ack and redirect: drop data, output NOP, pc_q<=redirect_pc, stay REQ.
  - ack, no redirect, stall_d=0: deliver combinationally (instr_f=imem_rdata, pc_f=pc_q), pc_q<=pc_q+PC_STEP, stay REQ.
  - ack, no redirect, stall_d=1: hold_instr<=imem_rdata, hold_pc<=pc_q, pc_q<=pc_q+PC_STEP, go HOLD.
  - no ack, redirect: target_q<=redirect_pc, go DROP.
  - no ack, no redirect: stay REQ, output NOP.
- HOLD state: imem_req=0.
  - redirect: discard hold, output NOP, pc_q<=redirect_pc, go REQ.
  - stall_d=0, no redirect: deliver hold_instr/hold_pc, go REQ.
  - stall_d=1: stay HOLD. instr_f is don't-care because fd_write=0.
- DROP state: imem_req=1, imem_addr=pc_q (the old address, kept stable until ack). Output NOP.
  - Further redirect: target_q<=redirect_pc (latest wins).
  - ack: data discarded, pc_q<=target_q, or redirect_pc if redirect is high in the same cycle, go REQ.
- Priority: rst > redirect > imem_ack > stall_d.
- Redirect during stall_d=1 is still honored. The flush takes effect on the next fd_write.
- PC arithmetic: 32-bit unsigned, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). No alignment check.
- Memory protocol:
  - One outstanding request. imem_ack is asserted only while imem_req=1. A same-cycle ack (zero wait) is legal.
  - imem_addr never changes between request and ack.
- Max throughput: one instruction per cycle with zero-wait memory and no stalls.

Test Plan:
- Zero-wait memory (ack same cycle), no stalls, rst released at cycle 0 -> fd_write=1 each cycle; pc_f=0,4,8,12 on consecutive cycles with matching instr_f.
- Memory with 2 wait cycles -> pattern NOP,NOP,instr(pc 0),NOP,NOP,instr(pc 4); imem_addr stable during waits.
- stall_d=1 for 3 cycles coinciding with ack for pc 8 -> fd_write=0 for 3 cycles, imem_req=0 in HOLD; on release instr(pc 8) delivered, next request addr 12.
- redirect to 32'h100 while request for 16 is outstanding -> DROP, returned word discarded (NOP), next request addr 32'h100, no pc 16/20 instruction ever delivered.
- redirect to 32'h40 in HOLD, then second redirect to 32'h80 during DROP -> hold discarded, final fetch addr 32'h80.
- rst asserted mid-DROP, RESET_PC=32'h200 -> outputs 0 during rst; first post-reset imem_addr=32'h200; PC wrap test from 32'hFFFF_FFFC -> next addr 0.
